// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, runtime frame format and a FWFT receive FIFO.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   rx_data             - asynchronous serial input, idle high
//   cfg_*               - baud divisor (clk cycles per 1/16 bit), word size, parity, stop bits;
//                         sampled at the start edge and held for the frame
//   rd_data/rd_*_err    - FIFO head word (right-justified) and its error flags
//   rd_valid/rd_ready   - read handshake, pop on rd_valid && rd_ready
//   fifo_count          - FIFO occupancy
//   overrun/ovr_clear   - sticky dropped-frame flag and its clear
//   break_det           - one-cycle pulse on a detected break
//   busy                - receiver FSM not idle
module uart_rx_fifo #(
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DIV_W         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_data,
  input  logic [DIV_W-1:0]              cfg_baud_div,
  input  logic [3:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_two_stop,
  output logic [MAX_DATA_BITS-1:0]      rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          ovr_clear,
  output logic                          break_det,
  output logic                          busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = MAX_DATA_BITS + 2;
  localparam logic [3:0]       MinBits = 4'd5;
  localparam logic [3:0]       MaxBits = 4'(MAX_DATA_BITS);
  localparam logic [DIV_W-1:0] DivOne  = 1;
  localparam logic [PtrW-1:0]  PtrOne  = 1;
  localparam logic [CntW-1:0]  CntOne  = 1;
  localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e state_q, state_d;

  logic                     sync1_q, sync2_q, line_prev_q;
  logic [DIV_W-1:0]         div_q, div_cnt_q;
  logic [3:0]               phase_q, nbits_q, bit_cnt_q, nbits_clamped;
  logic                     par_en_q, par_odd_q, two_stop_q;
  logic                     s7_q, s8_q, pbit_q, all_zero_q, ferr_q, stop_idx_q;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic                     break_det_q;

  logic start_edge, tick, at_p9, at_p15, maj, last_stop, brk, push, brk_pulse, perr;
  logic [EntW-1:0] push_word;

  assign start_edge = (state_q == StIdle) && line_prev_q && !sync2_q;
  assign tick       = (div_cnt_q == div_q - DivOne);
  assign at_p9      = tick && (phase_q == 4'd9);
  assign at_p15     = tick && (phase_q == 4'd15);
  // Majority of phase-7/8 samples and the live phase-9 sample.
  assign maj        = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);
  assign last_stop  = (stop_idx_q == two_stop_q);
  // Break is judged on the first stop bit only.
  assign brk        = !stop_idx_q && all_zero_q && !maj;
  assign perr       = par_en_q & ((^data_q) ^ pbit_q ^ par_odd_q);
  assign push_word  = {ferr_q | !maj, perr, data_q};

  always_comb begin
    nbits_clamped = cfg_data_bits;
    if (cfg_data_bits < MinBits) nbits_clamped = MinBits;
    else if (cfg_data_bits > MaxBits) nbits_clamped = MaxBits;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_edge) state_d = StStart;
      StStart: begin
        if (at_p9 && maj) state_d = StIdle;
        else if (at_p15)  state_d = StData;
      end
      StData:   if (at_p15 && bit_cnt_q == nbits_q) state_d = par_en_q ? StParity : StStop;
      StParity: if (at_p15) state_d = StStop;
      StStop: begin
        if (at_p9 && brk)            state_d = StBreak;
        else if (at_p9 && last_stop) state_d = StIdle;
      end
      StBreak:  if (sync2_q) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q != StIdle);
    push      = (state_q == StStop) && at_p9 && last_stop && !brk;
    brk_pulse = (state_q == StStop) && at_p9 && brk;
  end

  // Synchronizer, baud timing and frame datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      div_q       <= DivOne;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      nbits_q     <= MinBits;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      two_stop_q  <= 1'b0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      pbit_q      <= 1'b0;
      all_zero_q  <= 1'b0;
      ferr_q      <= 1'b0;
      stop_idx_q  <= 1'b0;
      break_det_q <= 1'b0;
    end else begin
      sync1_q     <= rx_data;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      break_det_q <= brk_pulse;
      if (start_edge) begin
        div_q      <= (cfg_baud_div == '0) ? DivOne : cfg_baud_div;
        nbits_q    <= nbits_clamped;
        par_en_q   <= cfg_parity_en;
        par_odd_q  <= cfg_parity_odd;
        two_stop_q <= cfg_two_stop;
        div_cnt_q  <= '0;
        phase_q    <= '0;
        bit_cnt_q  <= '0;
        data_q     <= '0;
        pbit_q     <= 1'b0;
        all_zero_q <= 1'b1;
        ferr_q     <= 1'b0;
        stop_idx_q <= 1'b0;
      end else begin
        if (tick) begin
          div_cnt_q <= '0;
          phase_q   <= phase_q + 4'd1;
          if (phase_q == 4'd7) s7_q <= sync2_q;
          if (phase_q == 4'd8) s8_q <= sync2_q;
        end else begin
          div_cnt_q <= div_cnt_q + DivOne;
        end
        if (at_p9) begin
          unique case (state_q)
            StData: begin
              data_q    <= data_q | ({{(MAX_DATA_BITS-1){1'b0}}, maj} << bit_cnt_q);
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (maj) all_zero_q <= 1'b0;
            end
            StParity: begin
              pbit_q <= maj;
              if (maj) all_zero_q <= 1'b0;
            end
            StStop:  if (!maj) ferr_q <= 1'b1;
            default: ;
          endcase
        end
        if (at_p15 && state_q == StStop) stop_idx_q <= 1'b1;
      end
    end
  end

  assign break_det = break_det_q;

  // Receive FIFO, first-word-fall-through
  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, pop, do_write, ovr_set;
  logic [EntW-1:0] head;

  assign full     = (count_q == CntFull);
  assign pop      = rd_valid && rd_ready;
  assign do_write = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)      rd_ptr_q <= rd_ptr_q + PtrOne;
      if (do_write && !pop)      count_q <= count_q + CntOne;
      else if (!do_write && pop) count_q <= count_q - CntOne;
      // A set in the same cycle beats the clear.
      if (ovr_set)        overrun <= 1'b1;
      else if (ovr_clear) overrun <= 1'b0;
    end
  end

  assign rd_valid      = (count_q != '0);
  assign fifo_count    = count_q;
  assign rd_data       = rd_valid ? head[MAX_DATA_BITS-1:0] : '0;
  assign rd_parity_err = rd_valid & head[MAX_DATA_BITS];
  assign rd_frame_err  = rd_valid & head[MAX_DATA_BITS+1];

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter MAX_DATA_BITS, default 8, giving rd_data width and the maximum runtime word size.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the receive FIFO word count; power of 2, >=2.
REQ-003 SHALL have parameter DIV_W, default 16, giving the baud-divisor width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port rx_data, input, 1, the asynchronous serial line, idle high.
REQ-007 SHALL have port cfg_baud_div, input, DIV_W, giving clk cycles per 1/16 bit; a value of 0 is treated as 1.
REQ-008 SHALL have port cfg_data_bits, input, 4, giving word size 5..MAX_DATA_BITS; out-of-range values are clamped to that range.
REQ-009 SHALL have ports cfg_parity_en, cfg_parity_odd and cfg_two_stop, input, 1 each, selecting parity enable, odd parity and 2 stop bits.
REQ-010 SHALL have port rd_data, output, MAX_DATA_BITS, the FIFO head word, right-justified, with unused upper bits 0.
REQ-011 SHALL have ports rd_parity_err and rd_frame_err, output, 1 each, the error flags stored with the head word.
REQ-012 SHALL have port rd_valid (output, 1) and port rd_ready (input, 1) forming the read handshake.
REQ-013 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1, giving the current occupancy.
REQ-014 SHALL have ports overrun (output, 1, sticky dropped-frame flag) and ovr_clear (input, 1, clears overrun).
REQ-015 SHALL have ports break_det (output, 1, one-cycle pulse) and busy (output, 1, high when the FSM is not IDLE).

Function
REQ-016 SHALL pass rx_data through a 2-flop synchronizer whose flops reset to 1.
REQ-017 SHALL generate a tick every cfg_baud_div clk cycles and count 16 ticks per bit (phase 0..15); both counters SHALL be zeroed at start-edge detection.
REQ-018 SHALL, in IDLE, detect a start edge when the synchronized line goes 1->0, and SHALL latch all cfg_* inputs at that cycle and hold them for the whole frame.
REQ-019 SHALL take each bit value as the majority of the samples at phases 7, 8 and 9, decided at phase 9.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-021 SHALL handle START as follows: majority 1 -> return to IDLE (false start, nothing written); majority 0 -> go to DATA at phase 15.
REQ-022 SHALL handle DATA as follows: shift in the latched word size LSB-first, then go to PARITY if parity is enabled, else to STOP.
REQ-023 SHALL set parity_err as follows: even mode when XOR(data, parity bit)=1; odd mode when XOR(data, parity bit)=0; parity_err is 0 when parity is disabled.
REQ-024 SHALL, in STOP, sample 1 or 2 stop bits and set frame_err if any stop-bit majority is 0.
REQ-025 SHALL, at phase 9 of the last stop bit, push {frame_err, parity_err, data} and enter IDLE in the same cycle, so the next start edge can be caught early.
REQ-026 SHALL treat a frame as a break when all data bits, the parity bit (if any) and the first stop bit are 0; it SHALL pulse break_det for one cycle, write nothing, and enter BREAK.
REQ-027 SHALL leave BREAK for IDLE only once the synchronized line reads 1.
REQ-028 SHALL implement the FIFO as first-word-fall-through with rd_valid = (fifo_count != 0); a pop occurs when rd_valid && rd_ready.
REQ-029 SHALL make a pushed word visible on rd_* with rd_valid=1 in the cycle after the push cycle.
REQ-030 SHALL, on a push while full without a same-cycle pop, drop the word and set overrun; on a push and pop in the same cycle while full, do both with no overrun and count unchanged.
REQ-031 SHALL make a pop when empty a no-op, wrap pointers modulo FIFO_DEPTH, and keep fifo_count within 0..FIFO_DEPTH.
REQ-032 SHALL clear overrun on ovr_clear; a set event in the same cycle wins over the clear.

Reset
REQ-033 SHALL, while reset is high, force: FSM=IDLE; FIFO pointers and fifo_count=0; rd_valid=0; rd_data=0; rd_parity_err=0; rd_frame_err=0; overrun=0; break_det=0; busy=0; synchronizer=1.
REQ-034 SHALL discard any partial frame when reset is asserted mid-frame, writing nothing to the FIFO.

Verification
REQ-035 SHALL cover: div=4, 8N1, send 0xA5 -> rd_valid within 640 cycles of the start edge, rd_data=0xA5, both error flags 0.
REQ-036 SHALL cover: 7E2, data 0x35, parity bit sent as 1 -> rd_data=0x35, rd_parity_err=1, rd_frame_err=0.
REQ-037 SHALL cover: rx low for 16 clk (4 ticks) at div=4 -> no push, FSM returns to IDLE, fifo_count=0.
REQ-038 SHALL cover: DEPTH=4, 5 frames with rd_ready=0 -> fifo_count=4, overrun=1, words 1-4 intact; ovr_clear pulse -> overrun=0.
REQ-039 SHALL cover: rx low for 12 bit times -> exactly one break_det pulse, no push; a following 0x5A frame is received correctly.
REQ-040 SHALL cover: reset during data bit 3 -> all outputs at reset values in the next cycle; the following 0xC3 frame is received correctly.
